// File: rtl/arbiter_wrr_pkt_n.sv
// arbiter_wrr_pkt_n: weighted round-robin packet arbiter with
// per-channel valid/ready and a registered, source-tagged output.
module arbiter_wrr_pkt_n #(
  parameter  int DWIDTH = 16,
  parameter  int N      = 4,
  parameter  int WWIDTH = 4,
  localparam int SWIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid [N],
  input  logic [DWIDTH-1:0]   in_data  [N],
  input  logic                in_last  [N],
  output logic                in_ready [N],
  input  logic [N*WWIDTH-1:0] weight,
  output logic                out_valid,
  output logic [DWIDTH-1:0]   out_data,
  output logic                out_last,
  output logic [SWIDTH-1:0]   out_src,
  input  logic                out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  state_t            state_nx;
  logic [SWIDTH-1:0] ptr;
  logic [SWIDTH-1:0] g;
  logic [SWIDTH-1:0] win;
  logic [SWIDTH-1:0] g_inc;
  logic [WWIDTH-1:0] credit;
  logic [WWIDTH-1:0] wsel;
  logic [WWIDTH-1:0] reload;
  logic [DWIDTH-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              any_req;
  logic              keep_credit;
  logic              slot_free;
  logic              acc;
  logic              acc_last;

  // circular first-requester search starting at ptr
  always_comb begin
    int idx;
    any_req = 1'b0;
    win     = ptr;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_req && in_valid[idx]) begin
        any_req = 1'b1;
        win     = SWIDTH'(idx);
      end
    end
  end

  // weight of the winner, with a zero weight meaning one packet
  always_comb begin
    wsel        = weight[int'(win)*WWIDTH +: WWIDTH];
    reload      = (wsel == '0) ? WWIDTH'(1) : wsel;
    keep_credit = (win == ptr) && (credit != '0);
    g_inc       = SWIDTH'((int'(g) + 1) % N);
  end

  // mux out the granted channel's beat
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(g) == i) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i];
        sel_last  = in_last[i];
      end
    end
  end

  // next state, handshake decode and per-channel ready
  always_comb begin
    state_nx  = state;
    slot_free = !reset && (!out_valid || out_ready);
    acc       = 1'b0;
    acc_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = 1'b0;
    end
    case (state)
      IDLE: begin
        if (any_req) state_nx = LOCKED;
      end
      LOCKED: begin
        for (int i = 0; i < N; i++) begin
          in_ready[i] = (int'(g) == i) && slot_free;
        end
        acc      = sel_valid && slot_free;
        acc_last = acc && sel_last;
        if (acc_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // grant, rotation pointer and packet credit
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      g      <= '0;
      credit <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        g <= win;
        if (!keep_credit) begin
          credit <= reload;
          ptr    <= win;
        end
      end
    end else if (acc_last) begin
      credit <= credit - WWIDTH'(1);
      if (credit == WWIDTH'(1)) ptr <= g_inc;
    end
  end

  // registered output beat, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_wrr_pkt_n.sv
// tb_arbiter_wrr_pkt_n: directed checks of the weighted
// round-robin packet arbiter, N=4.
module tb_arbiter_wrr_pkt_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [4];
  logic [15:0] in_data  [4];
  logic        in_last  [4];
  logic        in_ready [4];
  logic [15:0] weight;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;

  arbiter_wrr_pkt_n #(.DWIDTH(16), .N(4), .WWIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .weight(weight),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  int npk [4];
  int plen [4];
  int beat [4];
  int sent [4];
  int gbeat [4];
  int glen [4];

  int          lsrc [$];
  logic [15:0] ldat [$];
  logic        llst [$];
  int          lcyc [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = npk[i] > 0;
      if (v && beat[i] == gbeat[i] && glen[i] > 0) begin
        v = 1'b0;
        glen[i]--;
      end
      in_valid[i] = v;
      in_data[i]  = 16'((i << 12) | ((sent[i] & 255) << 4)
                        | (beat[i] & 15));
      in_last[i]  = (beat[i] == plen[i] - 1);
    end
  endtask

  task automatic src_clear();
    for (int i = 0; i < 4; i++) begin
      npk[i] = 0; plen[i] = 1; beat[i] = 0;
      sent[i] = 0; gbeat[i] = -1; glen[i] = 0;
    end
    drive();
  endtask

  task automatic log_clear();
    lsrc.delete(); ldat.delete();
    llst.delete(); lcyc.delete();
  endtask

  task automatic cyc();
    logic acc [4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      acc[i] = in_valid[i] && in_ready[i];
    end
    if (!reset && out_valid && out_ready) begin
      lsrc.push_back(int'(out_src));
      ldat.push_back(out_data);
      llst.push_back(out_last);
      lcyc.push_back(ncyc);
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        beat[i]++;
        if (beat[i] == plen[i]) begin
          beat[i] = 0;
          sent[i]++;
          npk[i]--;
        end
      end
    end
    drive();
    #1;
    ncyc++;
  endtask

  task automatic do_reset();
    src_clear();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    log_clear();
  endtask

  task automatic run_until(input string tag,
                           input int n, input int budget);
    int b;
    b = 0;
    while (lsrc.size() < n && b < budget) begin
      cyc();
      b++;
    end
    chk(tag, lsrc.size(), n);
  endtask

  int          exp_fair [14];
  int          exp_cc [7];
  int          cnt [4];
  logic [15:0] snap;

  initial begin
    exp_fair = '{0, 1, 1, 2, 3, 3, 3,
                 0, 1, 1, 2, 3, 3, 3};
    exp_cc   = '{1, 2, 1, 1, 2, 1, 2};
    out_ready = 1'b1;
    weight    = 16'h1111;
    reset     = 1'b1;
    src_clear();
    npk[0] = 1;
    drive();
    cyc();
    cyc();
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ol", out_last, 0);
    chk("rst_os", out_src, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ir%0d", i), in_ready[i], 0);
    end

    // fairness with weights {1,2,0,3}
    weight = 16'h3021;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      npk[i] = 100;
      cnt[i] = 0;
    end
    drive();
    run_until("fair_cnt", 14, 60);
    for (int k = 0; k < 14 && k < lsrc.size(); k++) begin
      int s;
      s = exp_fair[k];
      chk($sformatf("fair_src%0d", k), lsrc[k], s);
      chk($sformatf("fair_dat%0d", k), ldat[k],
          16'((s << 12) | (cnt[s] << 4)));
      cnt[s]++;
    end

    // packet lock: 4-beat ch0 against 1-beat ch2
    weight = 16'h1111;
    do_reset();
    npk[0] = 1; plen[0] = 4;
    npk[2] = 1;
    drive();
    run_until("lock_cnt", 5, 40);
    if (lsrc.size() == 5) begin
      chk("lock_s0", lsrc[0], 0);
      chk("lock_s1", lsrc[1], 0);
      chk("lock_s2", lsrc[2], 0);
      chk("lock_s3", lsrc[3], 0);
      chk("lock_s4", lsrc[4], 2);
      chk("lock_l2", llst[2], 0);
      chk("lock_l3", llst[3], 1);
      chk("lock_d3", ldat[3], 16'h0003);
      chk("lock_d4", ldat[4], 16'h2000);
      chk("lock_burst", lcyc[3] - lcyc[0], 3);
      chk("lock_bubble", lcyc[4] - lcyc[3], 2);
    end

    // backpressure in the middle of a 6-beat ch1 packet
    do_reset();
    npk[1] = 1; plen[1] = 6;
    drive();
    run_until("bp_pre", 2, 20);
    out_ready = 1'b0;
    #1;
    snap = out_data;
    chk("bp_snap", snap, 16'h1002);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp_ov%0d", k), out_valid, 1);
      chk($sformatf("bp_od%0d", k), out_data, 16'h1002);
      chk($sformatf("bp_os%0d", k), out_src, 1);
      chk($sformatf("bp_ol%0d", k), out_last, 0);
      chk($sformatf("bp_ir%0d", k), in_ready[1], 0);
    end
    out_ready = 1'b1;
    run_until("bp_cnt", 6, 30);
    for (int k = 0; k < 6 && k < ldat.size(); k++) begin
      chk($sformatf("bp_dat%0d", k), ldat[k],
          16'(16'h1000 + k));
      chk($sformatf("bp_lst%0d", k), llst[k], k == 5);
    end

    // ch3 leaves a 2-cycle gap while ch0 waits
    do_reset();
    npk[3] = 1; plen[3] = 4;
    gbeat[3] = 2; glen[3] = 2;
    drive();
    cyc();
    npk[0] = 1;
    drive();
    cyc();
    chk("gap_ir0", in_ready[0], 0);
    run_until("gap_cnt", 5, 40);
    if (lsrc.size() == 5) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("gap_s%0d", k), lsrc[k], 3);
        chk($sformatf("gap_d%0d", k), ldat[k],
            16'(16'h3000 + k));
      end
      chk("gap_s4", lsrc[4], 0);
      chk("gap_hole", lcyc[2] - lcyc[1], 3);
      chk("gap_l3", llst[3], 1);
    end

    // leftover credit of ch1 is dropped when ch2 takes over
    weight = 16'h1121;
    do_reset();
    npk[1] = 1;
    npk[2] = 1;
    drive();
    run_until("cc_ph1", 2, 20);
    npk[1] = 3;
    npk[2] = 2;
    drive();
    run_until("cc_cnt", 7, 40);
    for (int k = 0; k < 7 && k < lsrc.size(); k++) begin
      chk($sformatf("cc_s%0d", k), lsrc[k], exp_cc[k]);
    end

    // reset in the middle of a ch1 packet
    weight = 16'h1111;
    do_reset();
    npk[1] = 1; plen[1] = 8;
    drive();
    run_until("mr_pre", 2, 20);
    chk("mr_ov_pre", out_valid, 1);
    reset = 1'b1;
    cyc();
    chk("mr_ov", out_valid, 0);
    chk("mr_od", out_data, 0);
    chk("mr_ol", out_last, 0);
    chk("mr_os", out_src, 0);
    chk("mr_ir1", in_ready[1], 0);
    reset = 1'b0;
    src_clear();
    log_clear();
    npk[0] = 1;
    npk[3] = 1;
    drive();
    run_until("mr_cnt", 2, 20);
    if (lsrc.size() == 2) begin
      chk("mr_s0", lsrc[0], 0);
      chk("mr_s1", lsrc[1], 3);
      chk("mr_d0", ldat[0], 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_wrr_pkt_n.md
Name: arbiter_wrr_pkt_n

Overview:
- N-input weighted round-robin packet arbiter with valid/ready on every channel and a registered output stage.
- Successor to the single-beat RR arbiter:
  - grants are held for a whole packet (in_last framed);
  - each channel may send up to weight[i] consecutive packets before priority rotates;
  - output is registered and carries the source channel index.
- Sits in front of shared engine/memory ports where multi-beat requests must not interleave.

Parameters:
- DWIDTH, 16, data width per channel.
- N, 4, number of input channels (N>=1).
- WWIDTH, 4, width of each per-channel weight field.
- SWIDTH, (N>1 ? $clog2(N) : 1), width of out_src (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  [N-1:0] unpacked  channel beat valid.
- in_data  input  [DWIDTH-1:0] x N unpacked  channel beat data.
- in_last  input  [N-1:0] unpacked  final beat of packet.
- in_ready  output  [N-1:0] unpacked  beat accepted when in_valid & in_ready.
- weight  input  N*WWIDTH packed  packets per turn; channel i in bits [i*WWIDTH +: WWIDTH]; 0 treated as 1.
- out_valid  output  1  registered beat valid.
- out_data  output  DWIDTH  registered beat data.
- out_last  output  1  registered last flag.
- out_src  output  SWIDTH  index of the channel that produced the beat.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (synchronous, active-high; also applies mid-packet): state=IDLE, ptr=0, credit=0, g=0.
  - Outputs held at 0: out_valid, out_data, out_last, out_src, all in_ready.
  - Any partial packet or held output beat is discarded.
- State IDLE (no lock): all in_ready=0.
  - If any in_valid, the winner w is the first requesting index at or after ptr, searching circularly.
  - If w==ptr and credit>0, credit is kept. Otherwise credit<=max(weight[w],1) and ptr<=w.
  - Then g<=w and go to LOCKED. IDLE always costs 1 cycle, so there is a 1-cycle bubble between packets.
  - weight is sampled only at credit reload.
- State LOCKED:
  - in_ready[g]=(!out_valid | out_ready). All other in_ready=0.
  - A beat is accepted when in_valid[g] & in_ready[g]. On acceptance, next cycle out_valid=1, out_data=in_data[g], out_last=in_last[g], out_src=g (1-cycle latency).
  - If no beat is accepted and out_ready=1, out_valid<=0.
  - Output register holds stable while out_valid & !out_ready.
  - Full throughput: 1 beat/cycle inside a packet when out_ready stays high.
  - in_valid[g] deasserting mid-packet: lock is held (no abort, no timeout). Other channels wait.
  - Accepting a beat with in_last=1:
    - credit is decremented.
    - If the new credit==0: ptr<=(g+1) mod N.
    - state<=IDLE.
- Credit is an internal WWIDTH-bit counter, never negative. N=1 degenerates to a packet-framed registered pipe.
- Simultaneous events:
  - Last-beat acceptance and output drain in the same cycle are both honoured.
  - Requests arriving in the IDLE cycle take part in that cycle's arbitration.
- Fairness: with all channels continuously requesting, channel i receives exactly max(weight[i],1) packets per rotation.

Test Plan:
- Reset mid-packet: ch1 mid-packet with out_valid=1, assert reset 1 cycle -> next cycle all outputs 0, ptr=0. Subsequent grant goes to the lowest requesting index.
- WRR fairness: N=4, weights {1,2,0,3}, all channels sending 1-beat packets continuously with out_ready=1 -> out_src sequence 0,1,1,2,3,3,3 then repeats.
- Packet lock: ch0 sends 4 beats (last on beat 4) while ch2 requests throughout -> out_src=0 for 4 consecutive beats with no ch2 interleave. ch2 is granted after the 1-cycle IDLE bubble.
- Backpressure: out_ready held low 3 cycles mid-packet -> out_data/out_last/out_src stable, in_ready[g]=0, no beat lost or duplicated (compare against a scoreboard).
- Gap mid-packet: ch3 drops in_valid for 2 cycles between beats 2 and 3 while ch0 requests -> grant stays on ch3, out_valid falls to 0, packet completes intact.
- Credit carry: weights ch1=2, only ch1 and ch2 requesting, ch1 idles after its first packet -> ch2 is granted, ptr=2. Ch1's leftover credit is discarded and reloaded at its next grant.
